calc1_port_seq: RTL and testbench

CALC1_PORT_SEQ -- requirements
Module: calc1_port_seq

---
 rtl/calc1_port_seq.sv | 157 +++++++++++++++
 tb/tb_calc1_port_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_seq.sv
// calc1_port_seq
// Sequences one request at a time onto a calc1-style command port: the
// command goes out with the first operand, followed by the second operand
// with a zero command. The sequencer then waits a bounded number of cycles
// for a non-zero response code and presents the captured result to the
// consumer with a valid/ready handshake.
//
// Parameters
//   TIMEOUT  cycles to wait for a calc1 response before reporting code 00
//   DW       operand/result width
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  upstream request valid
//   req_ready  sequencer idle and able to accept a request
//   req_cmd    command forwarded unmodified to calc1
//   req_op1    first operand
//   req_op2    second operand
//   cmd_in     command driven to the calc1 port
//   data_in    operand driven to the calc1 port
//   out_resp   calc1 response: 00 none, 01 ok, 10 over/underflow, 11 invalid
//   data_out   calc1 result
//   rsp_valid  captured result valid to consumer
//   rsp_ready  consumer accepts the result
//   rsp_code   captured response code; 00 means timeout
//   rsp_data   captured result; 0 on timeout
module calc1_port_seq #(
    parameter int TIMEOUT = 64,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_cmd,
    input  logic [DW-1:0] req_op1,
    input  logic [DW-1:0] req_op2,
    output logic [3:0]    cmd_in,
    output logic [DW-1:0] data_in,
    input  logic [1:0]    out_resp,
    input  logic [DW-1:0] data_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [1:0]    rsp_code,
    output logic [DW-1:0] rsp_data
);

    typedef enum logic [2:0] {
        IDLE,
        OP1,
        OP2,
        WAIT,
        DONE
    } state_t;

    // Last counter value before the wait is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        next_state;
    logic [3:0]    cmd_q;
    logic [DW-1:0] op1_q;
    logic [DW-1:0] op2_q;
    logic [7:0]    cnt;
    logic          got_resp;
    logic          timed_out;

    assign got_resp  = (out_resp != 2'b00);
    assign timed_out = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and port outputs
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        cmd_in     = '0;
        data_in    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = OP1;
                end
            end
            OP1: begin
                cmd_in     = cmd_q;
                data_in    = op1_q;
                next_state = OP2;
            end
            OP2: begin
                data_in    = op2_q;
                next_state = WAIT;
            end
            WAIT: begin
                // A response arriving on the timeout cycle still wins; both
                // cases leave for DONE, only the captured values differ.
                if (got_resp || timed_out) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latch, wait counter and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            cnt      <= '0;
            rsp_code <= '0;
            rsp_data <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                cmd_q <= req_cmd;
                op1_q <= req_op1;
                op2_q <= req_op2;
            end

            if (state == WAIT) begin
                cnt <= cnt + 8'd1;
            end else begin
                cnt <= '0;
            end

            if (state == WAIT) begin
                if (got_resp) begin
                    rsp_code <= out_resp;
                    rsp_data <= data_out;
                end else if (timed_out) begin
                    rsp_code <= 2'b00;
                    rsp_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc1_port_seq.sv
// Directed testbench for calc1_port_seq: a table of transactions with
// hand-computed responses, latencies and backpressure, plus hand-written
// sequences for stray responses, walking-one back-to-back requests and a
// reset during OP2.
module tb_calc1_port_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [3:0]  cmd_in;
    logic [31:0] data_in;
    logic [1:0]  out_resp;
    logic [31:0] data_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    calc1_port_seq #(.TIMEOUT(64), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .cmd_in    (cmd_in),
        .data_in   (data_in),
        .out_resp  (out_resp),
        .data_out  (data_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_code  (rsp_code),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        int          delay;     // WAIT cycle index on which the response is driven
        logic [1:0]  resp;      // 00 = never respond
        logic [31:0] data;      // data_out held throughout WAIT
        int          hold;      // cycles of rsp_ready=0 in DONE
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
        int          exp_lat;   // negedges from first WAIT cycle to rsp_valid
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_txn(input vec_t v, input bit keep_valid);
        int n;
        bit seen;
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_cmd   = v.cmd;
        req_op1   = v.op1;
        req_op2   = v.op2;
        rsp_ready = (v.hold == 0);
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
        check("cmd_in_op1", 64'(cmd_in), 64'(v.cmd));
        check("data_in_op1", 64'(data_in), 64'(v.op1));
        check("req_ready_busy", 64'(req_ready), 64'(0));
        @(negedge clk);
        check("cmd_in_op2", 64'(cmd_in), 64'(0));
        check("data_in_op2", 64'(data_in), 64'(v.op2));
        @(negedge clk);
        check("cmd_in_wait", 64'(cmd_in), 64'(0));
        check("data_in_wait", 64'(data_in), 64'(0));
        data_out = v.data;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            out_resp = (v.resp != 2'b00 && n == v.delay) ? v.resp : 2'b00;
            @(negedge clk);
            n++;
            out_resp = 2'b00;
            if (rsp_valid) seen = 1'b1;
        end
        check("rsp_latency", 64'(n), 64'(v.exp_lat));
        check("rsp_code", 64'(rsp_code), 64'(v.exp_code));
        check("rsp_data", 64'(rsp_data), 64'(v.exp_data));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_code", 64'(rsp_code), 64'(v.exp_code));
            check("bp_data", 64'(rsp_data), 64'(v.exp_data));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
        check("req_ready_after", 64'(req_ready), 64'(1));
    endtask

    initial begin
        vec_t w;
        //          cmd   op1           op2     dly resp  data          hold code  exp_data      lat
        vecs[0] = '{4'd1, 32'd5,        32'd7,   1, 2'b01, 32'd12,       0, 2'b01, 32'd12,        2};
        vecs[1] = '{4'd2, 32'd10,       32'd3,   0, 2'b01, 32'd7,        0, 2'b01, 32'd7,         1};
        vecs[2] = '{4'd5, 32'h1,        32'd4,   3, 2'b01, 32'd16,       0, 2'b01, 32'd16,        4};
        vecs[3] = '{4'd6, 32'h80,       32'd3,   2, 2'b01, 32'd16,       0, 2'b01, 32'd16,        3};
        vecs[4] = '{4'd2, 32'd0,        32'd1,   0, 2'b10, 32'hFFFFFFFF, 0, 2'b10, 32'hFFFFFFFF,  1};
        vecs[5] = '{4'd3, 32'd1,        32'd1,   0, 2'b11, 32'd0,        0, 2'b11, 32'd0,         1};
        vecs[6] = '{4'd1, 32'd2,        32'd2,   0, 2'b00, 32'hDEADBEEF, 0, 2'b00, 32'd0,        64};
        vecs[7] = '{4'd1, 32'd3,        32'd4,  63, 2'b01, 32'd7,        0, 2'b01, 32'd7,        64};
        vecs[8] = '{4'd2, 32'd6,        32'd1,  62, 2'b10, 32'd5,        0, 2'b10, 32'd5,        63};
        vecs[9] = '{4'd1, 32'd100,      32'd200, 1, 2'b01, 32'd300,     10, 2'b01, 32'd300,       2};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_op1   = '0;
        req_op2   = '0;
        out_resp  = 2'b00;
        data_out  = '0;
        rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_cmd_in", 64'(cmd_in), 64'(0));
        check("rst_data_in", 64'(data_in), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_code", 64'(rsp_code), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], 1'b0);
        end

        // Stray response while idle must be ignored.
        out_resp = 2'b01;
        data_out = 32'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_rsp_valid", 64'(rsp_valid), 64'(0));
            check("stray_req_ready", 64'(req_ready), 64'(1));
            check("stray_rsp_data", 64'(rsp_data), 64'(300));
            check("stray_cmd_in", 64'(cmd_in), 64'(0));
        end
        out_resp = 2'b00;

        // Walking-one adds, req_valid held high across transactions.
        for (int k = 0; k < 32; k++) begin
            w = '{4'd1, 32'h1 << k, 32'd0, 1, 2'b01, 32'h1 << k, 0, 2'b01, 32'h1 << k, 2};
            run_txn(w, 1'b1);
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Reset during OP2 aborts the transaction.
        req_valid = 1'b1;
        req_cmd   = 4'd1;
        req_op1   = 32'd9;
        req_op2   = 32'd8;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_op2_data", 64'(data_in), 64'(8));
        reset = 1'b1;
        #1;
        check("mid_rst_cmd_in", 64'(cmd_in), 64'(0));
        check("mid_rst_data_in", 64'(data_in), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        out_resp = 2'b01;
        data_out = 32'd17;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        end
        out_resp = 2'b00;
        w = '{4'd1, 32'd20, 32'd22, 0, 2'b01, 32'd42, 0, 2'b01, 32'd42, 1};
        run_txn(w, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
